// File: rtl/clock_divider_multi.sv
// clock_divider_multi
//   Multi-channel clock divider. Each channel has a runtime-programmable
//   divisor and produces a one-cycle tick plus a square wave from clk.
//   Everything is on clk. The design never creates a derived clock.
//
//   Optional build macro: CLKDIV_SHADOW_EN
//     undefined : an accepted divisor write loads at once and restarts that
//                 channel. cfg_ready is tied high.
//     defined   : an accepted write is held in a per-channel pending
//                 register. It is applied at that channel's next wrap edge,
//                 or at a sync edge. cfg_ready stays low while any update
//                 is pending.
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   run       in   [CHANNELS] per-channel count enable
//   sync      in   restart all channels in phase
//   cfg_we    in   divisor write strobe
//   cfg_ch    in   [CH_W] channel being written
//   cfg_div   in   [WIDTH] new divisor (must be >= 2)
//   cfg_ready out  write accepted when high
//   div_err   out  sticky flag for any rejected write
//   tick      out  [CHANNELS] one-cycle pulse per period
//   clk_out   out  [CHANNELS] square wave per channel
module clock_divider_multi #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4,
  parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] run,
  input  logic                sync,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  output logic                cfg_ready,
  output logic                div_err,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] clk_out
);

  localparam logic [WIDTH-1:0] LP_DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [CH_W:0]    LP_CH_LIM  = (CH_W+1)'(CHANNELS);

  logic [WIDTH-1:0]    r_cnt [CHANNELS];
  logic [WIDTH-1:0]    r_div [CHANNELS];
  logic [CHANNELS-1:0] r_tick;
  logic [CHANNELS-1:0] r_clk_out;
  logic                r_div_err;

  logic                w_accept;
  logic [CHANNELS-1:0] w_wr_sel;
  logic [CHANNELS-1:0] w_last;
  logic [CHANNELS-1:0] w_rise;

  // The channel-range check is one bit wider than cfg_ch, so a
  // power-of-two CHANNELS still compares correctly.
  assign w_accept = cfg_we & cfg_ready &
                    ({1'b0, cfg_ch} < LP_CH_LIM) &
                    (cfg_div >= WIDTH'(2));

  // The rise point is div - floor(div/2) - 1. The high phase then lasts
  // floor(div/2) cycles and ends at the wrap. For an even div this is the
  // same point as div/2 - 1.
  always_comb begin
    w_wr_sel = '0;
    w_last   = '0;
    w_rise   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_wr_sel[i] = w_accept && (cfg_ch == CH_W'(i));
      w_last[i]   = (r_cnt[i] == r_div[i] - WIDTH'(1));
      w_rise[i]   = (r_cnt[i] == r_div[i] - (r_div[i] >> 1) - WIDTH'(1));
    end
  end

`ifdef CLKDIV_SHADOW_EN
  logic [WIDTH-1:0]    r_pend_div [CHANNELS];
  logic [CHANNELS-1:0] r_pend_vld;
  logic                r_cfg_ready;
  logic [CHANNELS-1:0] w_apply;
  logic [CHANNELS-1:0] w_pend_nxt;

  // A pending divisor lands at the channel's own wrap edge or at any sync.
  // While run is low the wrap never arrives, so the update keeps waiting.
  always_comb begin
    w_apply    = '0;
    w_pend_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_apply[i]    = r_pend_vld[i] & (sync | (run[i] & w_last[i]));
      w_pend_nxt[i] = w_wr_sel[i] | (r_pend_vld[i] & ~w_apply[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_vld  <= '0;
      r_cfg_ready <= 1'b1;
      for (int i = 0; i < CHANNELS; i++) r_pend_div[i] <= LP_DEF_DIV;
    end else begin
      r_pend_vld  <= w_pend_nxt;
      r_cfg_ready <= ~|w_pend_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_wr_sel[i]) r_pend_div[i] <= cfg_div;
      end
    end
  end

  assign cfg_ready = r_cfg_ready;
`else
  assign cfg_ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= '0;
        r_div[i] <= LP_DEF_DIV;
      end
      r_tick    <= '0;
      r_clk_out <= '0;
      r_div_err <= 1'b0;
    end else begin
      if (cfg_we && !w_accept) r_div_err <= 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync) begin
          r_cnt[i]     <= '0;
          r_tick[i]    <= 1'b0;
          r_clk_out[i] <= 1'b0;
        end
`ifndef CLKDIV_SHADOW_EN
        // A write overrides a wrap on the same edge, so no tick is emitted.
        else if (w_wr_sel[i]) begin
          r_cnt[i]     <= '0;
          r_tick[i]    <= 1'b0;
          r_clk_out[i] <= 1'b0;
        end
`endif
        else if (run[i]) begin
          if (w_last[i]) begin
            r_cnt[i]     <= '0;
            r_tick[i]    <= 1'b1;
            r_clk_out[i] <= 1'b0;
          end else begin
            r_cnt[i]  <= r_cnt[i] + WIDTH'(1);
            r_tick[i] <= 1'b0;
            if (w_rise[i]) r_clk_out[i] <= 1'b1;
          end
        end else begin
          r_tick[i] <= 1'b0;
        end
`ifdef CLKDIV_SHADOW_EN
        if (w_apply[i]) r_div[i] <= r_pend_div[i];
`else
        if (w_wr_sel[i]) r_div[i] <= cfg_div;
`endif
      end
    end
  end

  assign tick    = r_tick;
  assign clk_out = r_clk_out;
  assign div_err = r_div_err;

endmodule

// File: tb/tb_clock_divider_multi.sv
module tb_clock_divider_multi;
  localparam int CH  = 3;
  localparam int W   = 16;
  localparam int DEF = 4;
  localparam int CHW = 2;
`ifdef CLKDIV_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] run;
  logic          sync;
  logic          cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [W-1:0]  cfg_div;
  logic          cfg_ready;
  logic          div_err;
  logic [CH-1:0] tick;
  logic [CH-1:0] clk_out;

  always #5 clk = ~clk;

  clock_divider_multi #(
    .CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .sync(sync),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .div_err(div_err),
    .tick(tick), .clk_out(clk_out)
  );

  // Reference model: cycle position within the period, plus the divisor.
  // clk_out follows directly from the position: it is high for the last
  // floor(div/2) positions of each period.
  int          m_cnt  [CH];
  int          m_div  [CH];
  int          m_pdiv [CH];
  bit          m_pend [CH];
  bit [CH-1:0] m_tick  = '0;
  bit          m_err   = 1'b0;
  bit          m_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit acc;
    bit hit;
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        m_cnt[i] = 0; m_div[i] = DEF; m_pend[i] = 1'b0; m_pdiv[i] = DEF;
      end
      m_tick = '0; m_err = 1'b0; m_ready = 1'b1;
    end else begin
      acc = cfg_we && m_ready && (int'(cfg_div) >= 2) && (int'(cfg_ch) < CH);
      if (cfg_we && !acc) m_err = 1'b1;
      for (int i = 0; i < CH; i++) begin
        hit = acc && (int'(cfg_ch) == i);
        if (sync) begin
          m_cnt[i] = 0; m_tick[i] = 1'b0;
          if (SHADOW && m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 1'b0; end
          if (!SHADOW && hit) m_div[i] = int'(cfg_div);
        end else if (!SHADOW && hit) begin
          m_div[i] = int'(cfg_div); m_cnt[i] = 0; m_tick[i] = 1'b0;
        end else if (run[i]) begin
          m_tick[i] = (m_cnt[i] + 1 == m_div[i]);
          m_cnt[i]  = (m_cnt[i] + 1) % m_div[i];
          if (m_tick[i] && m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 1'b0; end
        end else begin
          m_tick[i] = 1'b0;
        end
        if (SHADOW && hit) begin m_pend[i] = 1'b1; m_pdiv[i] = int'(cfg_div); end
      end
      m_ready = 1'b1;
      for (int i = 0; i < CH; i++) if (m_pend[i]) m_ready = 1'b0;
    end
  endtask

  task automatic cycle();
    logic [CH-1:0] exp_clk;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < CH; i++) exp_clk[i] = (m_cnt[i] >= m_div[i] - m_div[i] / 2);
    chk("tick",      32'(tick),      32'(m_tick));
    chk("clk_out",   32'(clk_out),   32'(exp_clk));
    chk("div_err",   32'(div_err),   32'(m_err));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
  endtask

  initial begin
    int n;
    reset = 1'b1; run = '0; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    repeat (3) cycle();
    chk("rst_tick",  32'(tick),      32'd0);
    chk("rst_clk",   32'(clk_out),   32'd0);
    chk("rst_err",   32'(div_err),   32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);

    // Defaults, div=4 on every channel: edge k gives cnt = k mod 4.
    reset = 1'b0; run = '1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      chk("t1_tick", 32'(tick),    (k % 4 == 0) ? 32'd7 : 32'd0);
      chk("t1_clk",  32'(clk_out), (k % 4 >= 2) ? 32'd7 : 32'd0);
    end

    // Channel 1 -> div 5.
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd5;
    cycle();
    cfg_we = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      cycle();
`ifndef CLKDIV_SHADOW_EN
      chk("t2_tick1", 32'(tick[1]),    32'(k % 5 == 0));
      chk("t2_clk1",  32'(clk_out[1]), 32'(k % 5 >= 3));
`endif
    end

    // Illegal writes: div 1, div 0, channel 3 (out of range).
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd1; cycle();
    cfg_div = 16'd0; cycle();
    cfg_ch = 2'd3; cfg_div = 16'd6; cycle();
    cfg_we = 1'b0;
    repeat (4) cycle();
    chk("t3_err", 32'(div_err), 32'd1);

    // Pause channel 0 at cnt=2.
    n = 0;
    while (m_cnt[0] != 2 && n < 16) begin cycle(); n++; end
    run[0] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cycle();
      chk("t4_tick0", 32'(tick[0]),    32'd0);
      chk("t4_clk0",  32'(clk_out[0]), 32'd1);
    end
    run[0] = 1'b1;
    cycle(); chk("t4_resume1", 32'(tick[0]), 32'd0);
    cycle(); chk("t4_resume2", 32'(tick[0]), 32'd1);

    // Equalise divisors, skew phases, then sync.
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd4; cycle();
    cfg_we = 1'b0; run = 3'b011; cycle();
    run = '1; repeat (5) cycle();
    sync = 1'b1; cycle(); sync = 1'b0;
    chk("t5_clk",  32'(clk_out), 32'd0);
    chk("t5_tick", 32'(tick),    32'd0);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      chk("t5_coinc", 32'(tick), (k % 4 == 0) ? 32'd7 : 32'd0);
    end

`ifdef CLKDIV_SHADOW_EN
    reset = 1'b1; cycle();
    reset = 1'b0; run = '1; cycle();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd8; cycle();
    chk("t6_ready_low", 32'(cfg_ready), 32'd0);
    cfg_ch = 2'd2; cfg_div = 16'd6; cycle();
    cfg_we = 1'b0;
    chk("t6_err", 32'(div_err), 32'd1);
    chk("t6_ready_low2", 32'(cfg_ready), 32'd0);
    cycle();
    chk("t6_old_tick", 32'(tick[0]), 32'd1);
    chk("t6_ready_hi", 32'(cfg_ready), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      chk("t6_tick8", 32'(tick[0]),    32'(k == 8));
      chk("t6_clk8",  32'(clk_out[0]), 32'(k >= 4 && k < 8));
    end
`endif

    // Boundary divisors: 2 and the maximum 2^W-1.
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd2; cycle();
    cfg_we = 1'b0; repeat (6) cycle();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'hFFFF; cycle();
    cfg_we = 1'b0; repeat (6) cycle();

    // Randomised traffic against the model.
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 149) == 0);
      sync  = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < CH; i++) run[i] = ($urandom_range(0, 7) != 0);
      cfg_we  = ($urandom_range(0, 7) == 0);
      cfg_ch  = CHW'($urandom_range(0, 3));
      cfg_div = W'($urandom_range(0, 9));
      cycle();
    end
    reset = 1'b0; sync = 1'b0; cfg_we = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
